// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one registered ALU between two command requesters.
//
// One command is accepted at a time over a valid/ready request handshake. The
// command is issued to the ALU as a single-cycle enable pulse, the registered
// result is captured and returned on the owning requester's response channel.
// Divide-by-zero commands (fun 4'b0011 with b == 0) are answered directly
// with data 0 and the error flag set, and never drive the ALU.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-low reset
//   reqN_valid_i/reqN_ready_o request handshake for requester N (ready is
//                             combinational, everything else is registered)
//   reqN_a_i/_b_i/_fun_i      operands and function code
//   rspN_valid_o/rspN_ready_i response handshake for requester N
//   rspN_data_o/rspN_err_o    result and divide-by-zero error flag
//   alu_a_o/_b_o/_fun_o/_en_o registered command to the ALU
//   alu_out_i/alu_out_valid_i ALU registered result
//   busy_o                    high whenever the arbiter is not idle
//
// Configuration: define ALU_ARB_FIXED_PRIO_EN to replace round-robin with
// fixed priority (requester 0 always wins ties, no last-grant pointer).
module alu_req_arbiter #(
  parameter int unsigned OPER_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  input  logic [OPER_WIDTH-1:0] req0_a_i,
  input  logic [OPER_WIDTH-1:0] req0_b_i,
  input  logic [3:0]            req0_fun_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  input  logic [OPER_WIDTH-1:0] req1_a_i,
  input  logic [OPER_WIDTH-1:0] req1_b_i,
  input  logic [3:0]            req1_fun_i,
  output logic                  rsp0_valid_o,
  input  logic                  rsp0_ready_i,
  output logic [OUT_WIDTH-1:0]  rsp0_data_o,
  output logic                  rsp0_err_o,
  output logic                  rsp1_valid_o,
  input  logic                  rsp1_ready_i,
  output logic [OUT_WIDTH-1:0]  rsp1_data_o,
  output logic                  rsp1_err_o,
  output logic [OPER_WIDTH-1:0] alu_a_o,
  output logic [OPER_WIDTH-1:0] alu_b_o,
  output logic [3:0]            alu_fun_o,
  output logic                  alu_en_o,
  input  logic [OUT_WIDTH-1:0]  alu_out_i,
  input  logic                  alu_out_valid_i,
  output logic                  busy_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [3:0] FunDiv = 4'b0011;

  logic [1:0]            state_q, state_d;
  logic [OPER_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]            fun_q, fun_d;
  logic                  owner_q, owner_d;
  logic                  alu_en_q, alu_en_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [1:0]            rsp_err_q, rsp_err_d;
  logic [OUT_WIDTH-1:0]  rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic                  busy_q, busy_d;

  logic                  grant0, grant1, accept, owner_rsp_ready;
  logic [OPER_WIDTH-1:0] sel_a, sel_b;
  logic [3:0]            sel_fun;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign grant0 = req0_valid_i;
`else
  // last_grant_q holds the ID of the most recently accepted requester.
  logic last_grant_q, last_grant_d;
  assign grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
`endif
  assign grant1 = req1_valid_i & ~grant0;

  // READY is forced low while RST is asserted, not only after the reset edge.
  assign req0_ready_o = RST & (state_q == StIdle) & grant0;
  assign req1_ready_o = RST & (state_q == StIdle) & grant1;
  assign accept       = req0_ready_o | req1_ready_o;

  assign sel_a   = grant1 ? req1_a_i   : req0_a_i;
  assign sel_b   = grant1 ? req1_b_i   : req0_b_i;
  assign sel_fun = grant1 ? req1_fun_i : req0_fun_i;

  assign owner_rsp_ready = owner_q ? rsp1_ready_i : rsp0_ready_i;

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    owner_d     = owner_q;
    alu_en_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          a_d     = sel_a;
          b_d     = sel_b;
          fun_d   = sel_fun;
          owner_d = grant1;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_grant_d = grant1;
`endif
          if (sel_fun == FunDiv && sel_b == '0) begin
            state_d             = StResp;
            rsp_valid_d[grant1] = 1'b1;
            rsp_err_d[grant1]   = 1'b1;
            if (grant1) rsp1_data_d = '0;
            else        rsp0_data_d = '0;
          end else begin
            state_d  = StIssue;
            alu_en_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (alu_out_valid_i) begin
          state_d              = StResp;
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d[owner_q]   = 1'b0;
          if (owner_q) rsp1_data_d = alu_out_i;
          else         rsp0_data_d = alu_out_i;
        end
      end
      StResp: begin
        if (owner_rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      owner_q     <= 1'b0;
      alu_en_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      owner_q     <= owner_d;
      alu_en_q    <= alu_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
      busy_q      <= busy_d;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) last_grant_q <= 1'b1;
    else      last_grant_q <= last_grant_d;
  end
`endif

  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_fun_o    = fun_q;
  assign alu_en_o     = alu_en_q;
  assign rsp0_valid_o = rsp_valid_q[0];
  assign rsp1_valid_o = rsp_valid_q[1];
  assign rsp0_err_o   = rsp_err_q[0];
  assign rsp1_err_o   = rsp_err_q[1];
  assign rsp0_data_o  = rsp0_data_q;
  assign rsp1_data_o  = rsp1_data_q;
  assign busy_o       = busy_q;

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares the single registered ALU between two command requesters (host command path and internal sequencer) in the command-response execution datapath. Accepts one operation at a time over a valid/ready request handshake, issues it to the ALU for exactly one cycle, captures the registered result and returns it on the owning requester's response channel. Arbitration between simultaneous requests is round-robin. Divide-by-zero requests are trapped and answered with an error flag without driving the ALU.

## Interface
- OPER_WIDTH, 8, operand width (matches ALU operand width)
- OUT_WIDTH, 8, result width (matches ALU output width)

- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- REQ0_VALID / REQ1_VALID  in  1  request n has a command pending
- REQ0_READY / REQ1_READY  out  1  request n accepted this cycle when VALID&READY
- REQ0_A, REQ0_B / REQ1_A, REQ1_B  in  OPER_WIDTH  operands
- REQ0_FUN / REQ1_FUN  in  4  ALU function code, passed through unchanged
- RSP0_VALID / RSP1_VALID  out  1  response n holds a result
- RSP0_READY / RSP1_READY  in  1  requester n takes the response
- RSP0_DATA / RSP1_DATA  out  OUT_WIDTH  result
- RSP0_ERR / RSP1_ERR  out  1  response is an error (divide by zero)
- ALU_A, ALU_B  out  OPER_WIDTH  registered operands to ALU
- ALU_FUN  out  4  registered function code to ALU
- ALU_EN  out  1  registered ALU enable, one-cycle pulse per operation
- ALU_OUT  in  OUT_WIDTH  ALU registered result
- ALU_OUT_VALID  in  1  ALU result valid
- BUSY  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: REQn_READY is combinational: high only for the arbitration winner among asserted VALIDs; both low if none valid. On handshake: latch A, B, FUN, owner ID; go ISSUE. Only one READY ever high per cycle.
- Arbitration: single valid wins. Both valid: requester not granted last wins. LAST_GRANT pointer updates on every accepted request; reset value = 1 (requester 0 wins first tie).
- Divide-by-zero: accepted FUN=4'b0011 with B=0 skips ISSUE/WAIT; goes directly to RESP with DATA=0, ERR=1; ALU_EN never asserted.
- ISSUE: ALU_EN=1, ALU_A/B/FUN = latched command; go WAIT.
- WAIT: ALU_EN=0; ALU_A/B/FUN hold. On ALU_OUT_VALID: capture ALU_OUT into owner's RSP_DATA, ERR=0, go RESP. ALU_OUT_VALID in any other state ignored.
- RESP: owner's RSPn_VALID held high, DATA/ERR stable, until RSPn_READY; then RSP_VALID drops next cycle, go IDLE. Non-owner RSP_VALID stays 0. RSP_READY of non-owner ignored.
- REQn_READY is 0 in all states except IDLE; no new command accepted until response consumed.
- FUN codes (incl. undefined 4'b1111) forwarded unchanged; result whatever ALU returns.
- Widths: no truncation/extension in this block; DATA is ALU_OUT verbatim.

## Timing
- Reset (async, any state, including mid-operation): state=IDLE, all outputs 0 (REQn_READY 0 while in reset), LAST_GRANT=1, in-flight command discarded, no response produced.
- Accept at edge T0; ALU_EN high in cycle T0+1; ALU_OUT_VALID seen T0+2; RSPn_VALID high from T0+3.
- Divide-by-zero: RSPn_VALID high from T0+1.
- RSP_READY already high when RSP_VALID rises: consumed same cycle; IDLE next cycle; next accept earliest one cycle later. Minimum 4 cycles between accepts (2 for divide-by-zero).
- All outputs except REQn_READY are registered.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: round-robin replaced by fixed priority, requester 0 always wins ties; LAST_GRANT pointer removed.
- Not defined: round-robin as above.

## Test plan
- Single request: REQ0 A=8'd12, B=8'd5, FUN=0000 -> ALU_EN one pulse at T0+1 with A=12,B=5; RSP0_VALID at T0+3, DATA=8'd17, ERR=0; RSP1_VALID stays 0.
- Simultaneous REQ0/REQ1 held valid after reset (FUN=0001, A=9,B=3 / FUN=0100, A=8'hF0,B=8'h3C) -> order 0,1,0,1; DATA 6 then 8'h30; with ALU_ARB_FIXED_PRIO_EN requester 0 served continuously until it drops VALID.
- REQ1 A=7, B=0, FUN=0011 -> no ALU_EN, RSP1_VALID at T0+1, DATA=0, ERR=1; A=7,B=2 -> DATA=3, ERR=0.
- Backpressure: RSP0_READY low 5 cycles -> RSP0_VALID/DATA stable, REQ0/1_READY stay 0, BUSY=1; release -> IDLE next cycle.
- RST low during WAIT -> all outputs 0 immediately, no response after release; next REQ1 (tie with REQ0) granted to REQ0.
